// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pool_pkg
// Description : Shared types and constants for the 2x2 stride-2 pooling
//               engine: FSM state encoding, mode encoding and the address
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pool_pkg;

    // One window takes six cycles: four reads, one drain cycle for the last
    // read's data, one write.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_RD2  = 3'd3,
        S_RD3  = 3'd4,
        S_LAST = 3'd5,
        S_WR   = 3'd6
    } state_t;

    localparam logic c_MODE_MAX = 1'b0;
    localparam logic c_MODE_AVG = 1'b1;

    // Row-major address width for a square IMG_W x IMG_W map.
    function automatic int aw_for(input int img_w);
        return 2 * $clog2(img_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : pool_engine_if
// Description : Start handshake plus crd/cwr/csel memory bus of the pooling
//               engine. The slave modport is the engine; the master modport
//               is the controller/memory side.
// Ports       : ready, mode (start request, mode select); busy (run active);
//               crd, caddr_rd, cdata_rd (read port); cwr, caddr_wr, cdata_wr
//               (write port); csel (bank select for read or write).
// Revision    : 1.0 - initial release
// ============================================================================
interface pool_engine_if #(
    parameter int DATA_W = 20,
    parameter int AW     = 12,
    parameter int CSEL_W = 3
);
    logic              ready;
    logic              mode;
    logic              busy;
    logic              crd;
    logic [AW-1:0]     caddr_rd;
    logic [DATA_W-1:0] cdata_rd;
    logic              cwr;
    logic [AW-1:0]     caddr_wr;
    logic [DATA_W-1:0] cdata_wr;
    logic [CSEL_W-1:0] csel;

    modport slave (
        input  ready, mode, cdata_rd,
        output busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );

    modport master (
        output ready, mode, cdata_rd,
        input  busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );
endinterface
`default_nettype wire

// File: rtl/pool_reduce.sv
`default_nettype none
// ============================================================================
// Module      : pool_reduce
// Description : Per-window reducer. clear initialises the accumulator for the
//               selected mode, each sample folds one pixel in, result gives
//               the signed max or the rounded average of the samples.
// Ports       : clk, reset (async, active-high); clear, sample, mode, din
//               (control and pixel in); result (window result, DATA_W).
// Revision    : 1.0 - initial release
// ============================================================================
module pool_reduce
    import pool_pkg::*;
#(
    parameter int DATA_W = 20
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              clear,
    input  wire logic              sample,
    input  wire logic              mode,
    input  wire logic [DATA_W-1:0] din,
    output logic      [DATA_W-1:0] result
);

    // Most negative DATA_W value, sign-extended, so the first sample always
    // replaces it in max mode.
    localparam logic signed [DATA_W+1:0] c_MAX_INIT =
        {3'b111, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W+1:0] r_acc;
    logic signed [DATA_W+1:0] w_din_ext;
    logic signed [DATA_W+1:0] w_rnd;

    assign w_din_ext = {{2{din[DATA_W-1]}}, din};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (clear) begin
            r_acc <= (mode == c_MODE_MAX) ? c_MAX_INIT : '0;
        end else if (sample) begin
            if (mode == c_MODE_MAX) begin
                // Strict compare: ties keep the held value.
                if (w_din_ext > r_acc) begin
                    r_acc <= w_din_ext;
                end
            end else begin
                r_acc <= r_acc + w_din_ext;
            end
        end
    end

    // Four DATA_W samples plus the rounding term fit in DATA_W+2 bits, and
    // the quotient always fits back in DATA_W.
    assign w_rnd = (r_acc + 'sd2) >>> 2;

    always_comb begin
        result = r_acc[DATA_W-1:0];
        if (mode == c_MODE_AVG) begin
            result = w_rnd[DATA_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pool_engine.sv
`default_nettype none
// ============================================================================
// Module      : pool_engine
// Description : 2x2 stride-2 max/avg pooling over CH square IMG_W maps held
//               in the shared layer memory. Scans channel, output row, output
//               column; one window every six cycles.
// Ports       : clk, reset (async, active-high); bus (pool_engine_if.slave):
//               ready/mode/busy start handshake, crd/caddr_rd/cdata_rd read
//               port, cwr/caddr_wr/cdata_wr write port, csel bank select.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_engine
    import pool_pkg::*;
#(
    parameter int                DATA_W      = 20,
    parameter int                IMG_W       = 64,
    parameter int                CH          = 1,
    parameter int                CSEL_W      = 3,
    parameter logic [CSEL_W-1:0] RD_SEL_BASE = 3'b001,
    parameter logic [CSEL_W-1:0] WR_SEL_BASE = 3'b011
) (
    input wire logic     clk,
    input wire logic     reset,
    pool_engine_if.slave bus
);

    localparam int c_AW  = aw_for(IMG_W);
    localparam int c_HW  = $clog2(IMG_W / 2);
    localparam int c_CHW = (CH > 1) ? $clog2(CH) : 1;

    state_t           r_state;
    state_t           w_next;
    logic             r_mode;
    logic [c_HW-1:0]  r_row;
    logic [c_HW-1:0]  r_col;
    logic [c_CHW-1:0] r_ch;
    logic             w_last_win;
    logic             w_clear;
    logic             w_sample;
    logic [DATA_W-1:0] w_result;
    logic             w_rb;
    logic             w_cb;

    assign w_last_win = (r_ch == c_CHW'(CH - 1)) && (&r_row) && (&r_col);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.ready) w_next = S_RD0;
            S_RD0:   w_next = S_RD1;
            S_RD1:   w_next = S_RD2;
            S_RD2:   w_next = S_RD3;
            S_RD3:   w_next = S_LAST;
            S_LAST:  w_next = S_WR;
            S_WR:    w_next = w_last_win ? S_IDLE : S_RD0;
            default: w_next = S_IDLE;
        endcase
    end

    // Column is the fastest index, then row, then channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode <= c_MODE_MAX;
            r_row  <= '0;
            r_col  <= '0;
            r_ch   <= '0;
        end else if (r_state == S_IDLE && bus.ready) begin
            r_mode <= bus.mode;
            r_row  <= '0;
            r_col  <= '0;
            r_ch   <= '0;
        end else if (r_state == S_WR) begin
            if (w_last_win) begin
                r_row <= '0;
                r_col <= '0;
                r_ch  <= '0;
            end else if (&r_col) begin
                r_col <= '0;
                if (&r_row) begin
                    r_row <= '0;
                    r_ch  <= r_ch + 1'b1;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Read data arrives one cycle after its strobe, so samples are taken in
    // RD1..LAST for the reads issued in RD0..RD3.
    assign w_clear  = (r_state == S_RD0);
    assign w_sample = (r_state == S_RD1) || (r_state == S_RD2) ||
                      (r_state == S_RD3) || (r_state == S_LAST);

    pool_reduce #(
        .DATA_W (DATA_W)
    ) u_reduce (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .sample (w_sample),
        .mode   (r_mode),
        .din    (bus.cdata_rd),
        .result (w_result)
    );

    // Window pixel offset: bit 1 of the read index selects the row, bit 0
    // the column.
    always_comb begin
        w_rb = 1'b0;
        w_cb = 1'b0;
        case (r_state)
            S_RD1:   w_cb = 1'b1;
            S_RD2:   w_rb = 1'b1;
            S_RD3: begin
                w_rb = 1'b1;
                w_cb = 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs decode straight from the state so an asynchronous reset drops
    // the strobes immediately.
    always_comb begin
        bus.busy     = (r_state != S_IDLE);
        bus.crd      = 1'b0;
        bus.caddr_rd = '0;
        bus.cwr      = 1'b0;
        bus.caddr_wr = '0;
        bus.cdata_wr = '0;
        bus.csel     = '0;
        case (r_state)
            S_RD0, S_RD1, S_RD2, S_RD3: begin
                bus.crd      = 1'b1;
                // row*IMG_W + col with row = {r, rb}, col = {c, cb}.
                bus.caddr_rd = {r_row, w_rb, r_col, w_cb};
                bus.csel     = RD_SEL_BASE + CSEL_W'(r_ch);
            end
            S_LAST: begin
                bus.csel     = RD_SEL_BASE + CSEL_W'(r_ch);
            end
            S_WR: begin
                bus.cwr      = 1'b1;
                bus.caddr_wr = c_AW'({r_row, r_col});
                bus.cdata_wr = w_result;
                bus.csel     = WR_SEL_BASE + CSEL_W'(r_ch);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pool_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool_engine
// Description : Self-checking bench for pool_engine, IMG_W=4, CH=2. A bench
//               memory serves reads with one cycle of latency; expected
//               writes are queued when a run is started and popped as the
//               engine writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_engine;
    import pool_pkg::*;

    localparam int DATA_W = 20;
    localparam int IMG_W  = 4;
    localparam int CH     = 2;
    localparam int CSEL_W = 3;
    localparam int AW     = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pool_engine_if #(.DATA_W(DATA_W), .AW(AW), .CSEL_W(CSEL_W)) bus ();

    pool_engine #(
        .DATA_W      (DATA_W),
        .IMG_W       (IMG_W),
        .CH          (CH),
        .CSEL_W      (CSEL_W),
        .RD_SEL_BASE (3'b001),
        .WR_SEL_BASE (3'b011)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [AW-1:0]     addr;
        logic [CSEL_W-1:0] sel;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] mem [0:1][0:15];
    int n_checks    = 0;
    int n_errors    = 0;
    int n_writes    = 0;
    int busy_cycles = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bench memory: one-cycle read latency, bank chosen by csel.
    always @(posedge clk) begin
        if (bus.crd) begin
            bus.cdata_rd <= (bus.csel == 3'd1) ? mem[0][bus.caddr_rd] : mem[1][bus.caddr_rd];
        end
    end

    // Monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (bus.busy) begin
            busy_cycles++;
            chk("rd_wr_exclusive", {31'd0, bus.crd & bus.cwr}, 32'd0);
        end
        if (bus.crd) begin
            chk("rd_csel_range", {31'd0, (bus.csel == 3'd1) || (bus.csel == 3'd2)}, 32'd1);
        end
        if (bus.cwr) begin
            n_writes++;
            n_checks++;
            assert (sb.size() > 0) else begin
                n_errors++;
                $error("FAIL unexpected_write: observed addr %0h data %0h expected no write",
                       bus.caddr_wr, bus.cdata_wr);
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", 32'(bus.caddr_wr), 32'(e.addr));
                chk("wr_csel", 32'(bus.csel), 32'(e.sel));
                chk("wr_data", 32'(bus.cdata_wr), 32'(e.data));
            end
        end
    end

    function automatic logic [DATA_W-1:0] win(input int ch, input int r, input int c, input logic md);
        logic signed [DATA_W-1:0] v [4];
        logic signed [DATA_W-1:0] m;
        logic signed [DATA_W+1:0] s;
        int base;
        base = 2 * r * IMG_W + 2 * c;
        v[0] = mem[ch][base];
        v[1] = mem[ch][base + 1];
        v[2] = mem[ch][base + IMG_W];
        v[3] = mem[ch][base + IMG_W + 1];
        if (md == c_MODE_MAX) begin
            m = v[0];
            for (int k = 1; k < 4; k++) if (v[k] > m) m = v[k];
            return m;
        end
        s = '0;
        for (int k = 0; k < 4; k++) s = s + v[k];
        s = (s + 22'sd2) >>> 2;
        return s[DATA_W-1:0];
    endfunction

    task automatic push_run(input logic md);
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < IMG_W / 2; r++)
                for (int c = 0; c < IMG_W / 2; c++) begin
                    exp_t e;
                    e.addr = AW'(r * (IMG_W / 2) + c);
                    e.sel  = CSEL_W'(3 + ch);
                    e.data = win(ch, r, c, md);
                    sb.push_back(e);
                end
    endtask

    task automatic wait_busy(input string tag);
        int i;
        for (i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.busy) break;
        end
        chk(tag, {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic start_run(input logic md);
        @(negedge clk);
        bus.mode  = md;
        bus.ready = 1'b1;
        wait_busy("start_busy");
        bus.ready = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (!bus.busy) break;
            @(negedge clk);
        end
        chk("run_ends", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic run_summary(input int cyc, input int wr);
        chk("busy_cycles", 32'(busy_cycles), 32'(cyc));
        chk("write_count", 32'(n_writes), 32'(wr));
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        bus.ready = 1'b0;
        bus.mode  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem[0][i] = DATA_W'(i);
            mem[1][i] = DATA_W'($urandom);
        end
        // Channel-1 window 0 holds {-8,-3,-5,-20}: max must be -3.
        mem[1][0] = -20'sd8;
        mem[1][1] = -20'sd3;
        mem[1][4] = -20'sd5;
        mem[1][5] = -20'sd20;

        repeat (2) @(negedge clk);
        chk("rst_busy",     {31'd0, bus.busy}, 32'd0);
        chk("rst_crd",      {31'd0, bus.crd},  32'd0);
        chk("rst_cwr",      {31'd0, bus.cwr},  32'd0);
        chk("rst_csel",     32'(bus.csel),     32'd0);
        chk("rst_caddr_rd", 32'(bus.caddr_rd), 32'd0);
        chk("rst_caddr_wr", 32'(bus.caddr_wr), 32'd0);
        chk("rst_cdata_wr", 32'(bus.cdata_wr), 32'd0);
        reset = 1'b0;

        // Max run: channel 0 gives 5, 7, 13, 15.
        push_run(c_MODE_MAX);
        busy_cycles = 0;
        n_writes    = 0;
        start_run(c_MODE_MAX);
        wait_idle(100);
        run_summary(48, 8);

        // Avg run with mode toggled after start: results must stay averages.
        for (int i = 0; i < 16; i++) mem[1][i] = DATA_W'($urandom);
        mem[0][0] = 20'd1;       mem[0][1] = 20'd2;
        mem[0][4] = 20'd3;       mem[0][5] = 20'd5;
        mem[0][2] = -20'sd1;     mem[0][3] = -20'sd2;
        mem[0][6] = -20'sd3;     mem[0][7] = -20'sd5;
        mem[0][8] = 20'h7FFFF;   mem[0][9] = 20'h7FFFF;
        mem[0][12] = 20'h7FFFF;  mem[0][13] = 20'h7FFFF;
        mem[0][10] = 20'h80000;  mem[0][11] = 20'h80000;
        mem[0][14] = 20'h80000;  mem[0][15] = 20'h7FFFF;
        push_run(c_MODE_AVG);
        busy_cycles = 0;
        n_writes    = 0;
        start_run(c_MODE_AVG);
        bus.mode = c_MODE_MAX;
        wait_idle(100);
        run_summary(48, 8);

        // ready held high: second run starts one cycle after busy falls.
        push_run(c_MODE_MAX);
        push_run(c_MODE_MAX);
        busy_cycles = 0;
        n_writes    = 0;
        @(negedge clk);
        bus.mode  = c_MODE_MAX;
        bus.ready = 1'b1;
        wait_busy("b2b_first_busy");
        wait_idle(100);
        @(negedge clk);
        chk("b2b_restart", {31'd0, bus.busy}, 32'd1);
        bus.ready = 1'b0;
        wait_idle(100);
        run_summary(96, 16);

        // Reset during the first write cycle aborts the run.
        begin
            exp_t e;
            e.addr = '0;
            e.sel  = 3'b011;
            e.data = win(0, 0, 0, c_MODE_MAX);
            sb.push_back(e);
        end
        n_writes = 0;
        start_run(c_MODE_MAX);
        for (int i = 0; i < 20; i++) begin
            if (bus.cwr) break;
            @(negedge clk);
        end
        chk("abort_reached_wr", {31'd0, bus.cwr}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort_cwr",  {31'd0, bus.cwr},  32'd0);
        chk("abort_crd",  {31'd0, bus.crd},  32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_csel", 32'(bus.csel),     32'd0);
        repeat (5) @(negedge clk);
        chk("abort_writes", 32'(n_writes), 32'd1);
        reset = 1'b0;

        push_run(c_MODE_MAX);
        busy_cycles = 0;
        n_writes    = 0;
        start_run(c_MODE_MAX);
        wait_idle(100);
        run_summary(48, 8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
